// File: rtl/mealy_seq_detector.sv
// Serial pattern detector (Mealy, falling-edge state) with overlap select and saturating hit counter.
// y is combinational (0 cycles); y_q/state/count update one falling edge later; no backpressure, en gates consumption.
module mealy_seq_detector #(
    parameter int              PAT_W   = 4,
    parameter logic [PAT_W-1:0] PATTERN = 4'b1011,
    parameter int              CNT_W   = 8,
    localparam int             SW      = $clog2(PAT_W)
) (
    input  logic             clk,
    input  logic             res,
    input  logic             en,
    input  logic             i,
    input  logic             overlap,
    input  logic             clr_cnt,
    output logic             y,
    output logic             y_q,
    output logic [SW-1:0]    state,
    output logic [CNT_W-1:0] count
);

    if (PAT_W < 2 || PAT_W > 16) begin : g_bad_pat_w
        $error("mealy_seq_detector: PAT_W must be in 2..16");
    end
    if (CNT_W < 1 || CNT_W > 16) begin : g_bad_cnt_w
        $error("mealy_seq_detector: CNT_W must be in 1..16");
    end

    // Bit j of the pattern in stream order (j=0 is the first bit expected).
    function automatic int pat_bit(input int j);
        return int'(PATTERN[PAT_W-1-j]);
    endfunction

    // Longest prefix of PATTERN that is a suffix of (prefix of length s, b).
    function automatic int kmp_next(input int s, input int b);
        int best;
        int pos;
        int cb;
        bit ok;
        best = 0;
        for (int k = 1; k <= s + 1; k++) begin
            ok = 1'b1;
            for (int m = 0; m < k; m++) begin
                pos = s + 1 - k + m;
                cb  = (pos == s) ? b : pat_bit(pos);
                if (cb != pat_bit(m)) ok = 1'b0;
            end
            if (ok) best = k;
        end
        return best;
    endfunction

    // Longest proper border of PATTERN: restart point after an overlapped match.
    function automatic int border_len();
        int best;
        bit ok;
        best = 0;
        for (int k = 1; k < PAT_W; k++) begin
            ok = 1'b1;
            for (int m = 0; m < k; m++) begin
                if (pat_bit(m) != pat_bit(PAT_W - k + m)) ok = 1'b0;
            end
            if (ok) best = k;
        end
        return best;
    endfunction

    localparam int          BORDER   = border_len();
    localparam logic [SW-1:0] BORDER_S = BORDER[SW-1:0];
    localparam int          LAST     = PAT_W - 1;
    localparam logic [SW-1:0] LAST_S   = LAST[SW-1:0];
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    // Fallback tables indexed by state; entries beyond PAT_W-1 are unreachable.
    logic [SW-1:0] nxt0 [2**SW];
    logic [SW-1:0] nxt1 [2**SW];

    for (genvar s = 0; s < 2**SW; s++) begin : g_tab
        if (s < PAT_W) begin : g_live
            localparam int N0 = kmp_next(s, 0);
            localparam int N1 = kmp_next(s, 1);
            // The completing entry (N = PAT_W) truncates here but is overridden below.
            assign nxt0[s] = N0[SW-1:0];
            assign nxt1[s] = N1[SW-1:0];
        end else begin : g_dead
            assign nxt0[s] = '0;
            assign nxt1[s] = '0;
        end
    end

    logic [SW-1:0] state_nxt;

    always_comb begin
        y         = en && (state == LAST_S) && (i == PATTERN[0]);
        state_nxt = state;
        if (en) begin
            if (y) begin
                state_nxt = overlap ? BORDER_S : '0;
            end else begin
                state_nxt = i ? nxt1[state] : nxt0[state];
            end
        end
    end

    always_ff @(negedge clk or negedge res) begin
        if (!res) begin
            state <= '0;
            y_q   <= 1'b0;
        end else if (en) begin
            state <= state_nxt;
            y_q   <= y;
        end
    end

    // Clear wins over a simultaneous detection.
    always_ff @(negedge clk or negedge res) begin
        if (!res) begin
            count <= '0;
        end else if (clr_cnt) begin
            count <= '0;
        end else if (y && count != CNT_MAX) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: tb/tb_mealy_seq_detector.sv
// Directed bench for mealy_seq_detector: 1011 pattern (8-bit count) and 11 pattern (2-bit count).
module tb_mealy_seq_detector;

    logic       clk;
    logic       res;
    logic       en;
    logic       i;
    logic       overlap;
    logic       clr_cnt;
    logic       y;
    logic       y_q;
    logic [1:0] state;
    logic [7:0] count;
    logic       y2;
    logic       y_q2;
    logic [0:0] state2;
    logic [1:0] count2;

    int checks = 0;
    int errors = 0;

    mealy_seq_detector #(.PAT_W(4), .PATTERN(4'b1011), .CNT_W(8)) dut (
        .clk(clk), .res(res), .en(en), .i(i), .overlap(overlap), .clr_cnt(clr_cnt),
        .y(y), .y_q(y_q), .state(state), .count(count)
    );

    mealy_seq_detector #(.PAT_W(2), .PATTERN(2'b11), .CNT_W(2)) dut2 (
        .clk(clk), .res(res), .en(en), .i(i), .overlap(overlap), .clr_cnt(clr_cnt),
        .y(y2), .y_q(y_q2), .state(state2), .count(count2)
    );

    initial clk = 1'b1;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", tag, act, exp);
        end
    endtask

    // Entered 1 unit after a falling edge; returns 1 unit after the next one.
    task automatic step(input string tag, input logic b, input logic e, input logic ey, input int est);
        i  = b;
        en = e;
        #3;
        chk({tag, "_y"}, 32'(y), 32'(ey));
        @(negedge clk);
        #1;
        chk({tag, "_st"}, 32'(state), est);
        if (e) chk({tag, "_yq"}, 32'(y_q), 32'(ey));
    endtask

    task automatic step2(input string tag, input logic b, input logic c, input logic ey, input int ecnt);
        i       = b;
        en      = 1'b1;
        clr_cnt = c;
        #3;
        chk({tag, "_y"}, 32'(y2), 32'(ey));
        @(negedge clk);
        #1;
        chk({tag, "_cnt"}, 32'(count2), ecnt);
        chk({tag, "_st"}, 32'(state2), 1);
    endtask

    task automatic pulse_reset();
        res = 1'b0;
        #1;
        res = 1'b1;
    endtask

    initial begin
        res     = 1'b0;
        en      = 1'b0;
        i       = 1'b0;
        overlap = 1'b1;
        clr_cnt = 1'b0;
        #2;
        chk("rst_state", 32'(state), 0);
        chk("rst_yq",    32'(y_q),   0);
        chk("rst_count", 32'(count), 0);
        chk("rst_y",     32'(y),     0);
        @(negedge clk);
        #1;
        res = 1'b1;

        // Overlapping: 1,0,1,1,0,1,1
        step("ov1", 1, 1, 0, 1);
        step("ov2", 0, 1, 0, 2);
        step("ov3", 1, 1, 0, 3);
        step("ov4", 1, 1, 1, 1);
        step("ov5", 0, 1, 0, 2);
        step("ov6", 1, 1, 0, 3);
        step("ov7", 1, 1, 1, 1);
        chk("ov_count", 32'(count), 2);

        // Asynchronous reset with a partial match of length 2 in flight
        step("rs1", 0, 1, 0, 2);
        res = 1'b0;
        #1;
        chk("rs_state", 32'(state), 0);
        chk("rs_count", 32'(count), 0);
        chk("rs_yq",    32'(y_q),   0);
        res = 1'b1;

        // Non-overlapping: same stream
        overlap = 1'b0;
        step("no1", 1, 1, 0, 1);
        step("no2", 0, 1, 0, 2);
        step("no3", 1, 1, 0, 3);
        step("no4", 1, 1, 1, 0);
        step("no5", 0, 1, 0, 0);
        step("no6", 1, 1, 0, 1);
        step("no7", 1, 1, 0, 1);
        chk("no_count", 32'(count), 1);
        pulse_reset();

        // Enable gating between bits 3 and 4
        overlap = 1'b1;
        step("en1", 1, 1, 0, 1);
        step("en2", 0, 1, 0, 2);
        step("en3", 1, 1, 0, 3);
        for (int k = 0; k < 3; k++) step($sformatf("stall%0d", k), 1, 0, 0, 3);
        chk("en_hold_count", 32'(count), 0);
        step("en4", 1, 1, 1, 1);
        chk("en_count", 32'(count), 1);
        pulse_reset();

        // KMP fallback: 1,0,1,0,1,1
        step("fb1", 1, 1, 0, 1);
        step("fb2", 0, 1, 0, 2);
        step("fb3", 1, 1, 0, 3);
        step("fb4", 0, 1, 0, 2);
        step("fb5", 1, 1, 0, 3);
        step("fb6", 1, 1, 1, 1);
        chk("fb_count", 32'(count), 1);
        pulse_reset();

        // Saturation and clear on the 2-bit counter, pattern 11
        step2("sat1", 1, 0, 0, 0);
        step2("sat2", 1, 0, 1, 1);
        step2("sat3", 1, 0, 1, 2);
        step2("sat4", 1, 0, 1, 3);
        step2("sat5", 1, 0, 1, 3);
        step2("sat6", 1, 0, 1, 3);
        step2("clr",  1, 1, 1, 0);
        step2("after_clr", 1, 0, 1, 1);
        chk("sat_yq", 32'(y_q2), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mealy_seq_detector.md
# mealy_seq_detector

Parametrised serial pattern detector built as a Mealy machine on negative-edge state flip-flops. It is the general successor to the fixed two-flip-flop Mealy FSM. A pattern of configurable length and value is matched against a serial bit stream, with run-time selectable overlapping or non-overlapping detection. It provides a combinational Mealy output, a registered copy of that output, and a saturating detection counter. It sits between a serial input source and downstream status/interrupt logic.

## Interface
- PAT_W, 4, pattern length in bits; legal range 2..16.
- PATTERN, 4'b1011, pattern value, PAT_W bits; PATTERN[PAT_W-1] is the first bit expected on the stream.
- CNT_W, 8, width of detection counter; legal range 1..16.
- SW = $clog2(PAT_W), derived (localparam), width of STATE.
- CLK  input  1  clock; all state changes on the falling edge.
- RES  input  1  reset; asynchronous, active-low.
- EN  input  1  sample enable; I is consumed only on falling edges where EN=1.
- I  input  1  serial data bit.
- OVERLAP  input  1  1 = overlapping detection, 0 = non-overlapping; sampled every cycle.
- CLR_CNT  input  1  synchronous clear of COUNT.
- Y  output  1  Mealy match output; combinational from STATE, EN, I.
- Y_Q  output  1  Y registered on the falling edge of CLK.
- STATE  output  SW  current matched-prefix length, 0..PAT_W-1.
- COUNT  output  CNT_W  saturating number of detections.

## Operation
- STATE is the length of the longest suffix of the bits consumed since the last restart that is a proper prefix of PATTERN.
- Restart points are reset, and in non-overlap mode, every match.
- Y = EN & (STATE == PAT_W-1) & (I == PATTERN[0]).
- Next-state rules, evaluated only when EN=1:
  - Match bit (I equals PATTERN[PAT_W-1-STATE]) and not a completion: STATE+1.
  - Completion (Y=1), OVERLAP=1: STATE becomes the length of the longest proper border of PATTERN (a prefix that is also a suffix). This value is computed at elaboration time.
  - Completion (Y=1), OVERLAP=0: STATE becomes 0.
  - Mismatch: STATE becomes the longest suffix of (consumed prefix, I) that is a prefix of PATTERN, KMP fallback; 0 if none.
- The implementation may use a history shift register of the last PAT_W-1 consumed bits, or a precomputed fallback table. Observable STATE must equal the rule above.
- EN=0: STATE, Y_Q source and COUNT hold; Y=0.
- COUNT: increments by 1 on each falling edge with Y=1. It saturates at 2^CNT_W-1 and does not wrap.
- CLR_CNT=1 forces COUNT to 0 on the edge. CLR_CNT dominates a simultaneous detection, so the result is 0, not 1.
- OVERLAP toggled mid-stream affects only the next completion; STATE is not otherwise altered.

## Timing
- Reset (RES=0, asynchronous, immediate): STATE=0, Y_Q=0, COUNT=0. Y=0 while STATE=0 (PAT_W≥2).
- Reset takes effect mid-stream with no edge required; a partial match is discarded.
- Release of RES is synchronous to the next falling CLK edge; the first bit is consumed on that edge if EN=1.
- Y latency: 0 cycles. Y is valid during the low phase before the falling edge that consumes the final pattern bit.
- Y_Q, STATE, COUNT: update 1 falling edge after the bit that causes them. COUNT increments on the same edge Y_Q rises.
- I, EN, OVERLAP and CLR_CNT must be stable around the falling edge. The rising edge is unused.

## Test plan
- Reset/hold: RES=0 pulse mid-stream with STATE=2 -> STATE=0, Y_Q=0, COUNT=0 immediately, before any clock edge.
- Overlap detection: PATTERN=1011, OVERLAP=1, EN=1, stream 1,0,1,1,0,1,1 -> Y=1 on bits 4 and 7; STATE after bit 4 = 1; COUNT=2.
- Non-overlap detection: same stream, OVERLAP=0 -> Y=1 only on bit 4; STATE sequence 1,2,3,0,0,1,1; COUNT=1.
- Enable gating: EN=0 for 3 edges inserted between bits 3 and 4 of 1011 -> STATE holds at 3 and Y=0 while EN=0; detection on bit 4 once EN=1; COUNT=1.
- Saturation and clear: CNT_W=2, 5 back-to-back overlapped matches of PATTERN=11, PAT_W=2 -> COUNT 1,2,3,3,3. Then CLR_CNT=1 on a detecting edge -> COUNT=0.
- Fallback: PATTERN=1011, stream 1,0,1,0,1,1 -> STATE 1,2,3,2,3 then Y=1 on bit 6 (KMP fallback on the mismatch at bit 4).
